div_arbiter_ctrl: RTL

- Shares one iterative unsigned divider core between two requesters.
- Round-robin arbitration; one valid/ready request handshake per requester.
- Sequences the core: one-cycle start pulse, wait for done, capture results, return a response to the owning requester.
- Divide-by-zero is handled locally without starting the core. A watchdog covers a core that never completes.
- Sits between the user-side request logic and the divider core inside the top-level wrapper.

---
 rtl/div_arbiter_ctrl_pkg.sv | 28 ++
 rtl/div_arbiter_ctrl_arb.sv | 25 ++
 rtl/div_arbiter_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_arbiter_ctrl_pkg.sv
// Shared types and helpers for the two-requester divider arbiter/controller.
// Holds the FSM state encoding and the round-robin grant rule.
package div_arbiter_ctrl_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A lone requester always wins; on contention the pointer picks the winner.
  function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                               input logic ptr);
    logic [NREQ-1:0] g;
    g = '0;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = ptr ? 2'b10 : 2'b01;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/div_arbiter_ctrl_arb.sv
// Two-input round-robin arbiter. The pointer moves to the requester that did
// not own the transaction, and only when the owning response completes.
module div_rr_arbiter
  import div_arbiter_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  input  logic            last_owner,
  output logic [NREQ-1:0] grant,
  output logic            ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~last_owner;
    end
  end

  assign grant = rr_grant(valid, ptr);

endmodule

// File: rtl/div_arbiter_ctrl.sv
// Shares one iterative divider core between two requesters: arbitrates,
// issues a start pulse, waits for done (with watchdog) and returns the result.
module div_arbiter_ctrl
  import div_arbiter_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_done,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dbz,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [NREQ-1:0]   grant;
  logic              ptr;
  logic              owner;
  logic [WD_W-1:0]   wd;
  logic              sel_owner;
  logic [WIDTH-1:0]  sel_dividend, sel_divisor;
  logic              handshake, accept, wd_expired;

  div_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (req_valid),
    .advance    (accept),
    .last_owner (owner),
    .grant      (grant),
    .ptr        (ptr)
  );

  assign sel_owner    = grant[1];
  assign sel_dividend = sel_owner ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
  assign sel_divisor  = sel_owner ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];

  assign handshake  = (state == ST_IDLE) && (|grant);
  assign accept     = (state == ST_RESP) && rsp_ready[owner];
  assign wd_expired = (wd == WD_LAST);

  // Gated by rst so the accept is low the instant reset is applied.
  assign req_ready = ((state == ST_IDLE) && !rst) ? grant : '0;
  assign div_start = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (handshake) state_nx = (sel_divisor == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  if (div_done || wd_expired) state_nx = ST_RESP;
      ST_RESP:  if (accept) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner         <= 1'b0;
      wd            <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            owner        <= sel_owner;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            if (sel_divisor == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_dividend;
              rsp_dbz       <= 1'b1;
              rsp_err       <= 1'b0;
            end
          end
        end
        ST_ISSUE: wd <= '0;
        ST_WAIT: begin
          wd <= wd + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
          end else if (wd_expired) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b1;
          end
        end
        ST_RESP: begin
          if (accept) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
